knight_check: RTL and testbench
===============================

KNIGHT_CHECK -- requirements
Module: knight_check

Interface
REQ-001 Parameter CNT_W, default 8: width of the error and sweep counters.
REQ-002 Port ck, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port res, input, 1: reset; synchronous, active-high.
REQ-004 Port in_en, input, 1: sample strobe; `in` is consumed only on cycles with in_en=1.
REQ-005 Port in, input, 8: LED pattern from a knight flasher; legal values are one-hot.
REQ-006 Port pos, output, 3: index of the lit LED, taken from the last one-hot sample.
REQ-007 Port dir, output, 1: sweep direction, 0=up (LSB to MSB), 1=down; meaningful only while locked=1.
REQ-008 Port locked, output, 1: high while the checker is tracking a legal sequence.
REQ-009 Port err, output, 1: one-cycle pulse on a sequence violation detected while locked.
REQ-010 Port err_cnt, output, CNT_W: saturating count of err pulses.
REQ-011 Port sweep_cnt, output, CNT_W: wrapping count of completed 16-step sweeps while locked.

Function
REQ-012 Reference sequence: phase k=0..15 has pos=k for k<8 and pos=15-k for k>=8, and pattern = 1<<pos.
REQ-013 Consequence of REQ-012: patterns 0x80 and 0x01 each appear twice in a row (phases 7/8 and 15/0).
REQ-014 All outputs are registered and reflect a sample on the cycle after that sample's in_en=1 edge.
REQ-015 in_en=0: all state and outputs hold, except err, which is 0.
REQ-016 States: HUNT, ACQ, LOCK; locked=1 only in LOCK.
REQ-017 HUNT, one-hot sample q: store q's index as p, update pos, go to ACQ.
REQ-018 HUNT, non-one-hot sample (zero or multi-bit): stay in HUNT, no error.
REQ-019 ACQ, one-hot sample q with p<7 and q=p+1: phase=q, go to LOCK.
REQ-020 ACQ, one-hot sample q with p>0 and q=p-1: phase=15-q, go to LOCK.
REQ-021 ACQ, q=p=7: phase=8, go to LOCK; q=p=0: phase=0, go to LOCK.
REQ-022 ACQ, any other one-hot sample: p=q, stay in ACQ; non-one-hot sample: go to HUNT.
REQ-023 LOCK, sample equal to pattern(phase+1 mod 16): advance phase; pos and dir follow the new phase.
REQ-024 LOCK, match when advancing from phase 15 to 0: sweep_cnt increments, wrapping modulo 2^CNT_W.
REQ-025 LOCK, any mismatch, including non-one-hot: err=1 for one cycle, err_cnt+1 saturating at 2^CNT_W-1, locked=0, go to HUNT.
REQ-026 A mismatching sample is not reused for reacquisition; the next sample starts HUNT.
REQ-027 Errors are never flagged in HUNT or ACQ.

Reset
REQ-028 res=1 at an edge: state=HUNT, pos=0, dir=0, locked=0, err=0, err_cnt=0, sweep_cnt=0, phase=0.
REQ-029 res has priority over in_en on the same edge; the sample is discarded.
REQ-030 res asserted mid-sweep or mid-acquisition abandons all progress; relock needs two fresh samples.

Structure
REQ-031 Shared package knight_pkg holds the HUNT/ACQ/LOCK state encoding and the phase-to-pattern and phase-to-direction functions, shared with the flasher.
REQ-032 Sub-module knight_onehot_dec (8-bit in -> 3-bit index + onehot flag, combinational) holds the decode logic.

Verification
REQ-033 Reset, then in_en=1 with patterns 0x01,0x02,0x04 -> after the 2nd sample locked=1, dir=0; after the 3rd pos=2, err=0.
REQ-034 After lock, drive 32 flasher-order patterns (0x80,0x80 and 0x01,0x01 repeats included) -> sweep_cnt=2, err_cnt=0, dir toggles at 0x80 repeats and 0x01 repeats.
REQ-035 Locked at pos=3 going up, drive 0x20 -> err pulses 1 cycle, err_cnt=1, locked=0; then 0x40,0x80 -> locked=1 with phase=7.
REQ-036 Start unlocked, drive 0x80,0x80 -> locked=1, dir=1; next 0x40 accepted, pos=6.
REQ-037 With CNT_W=2, force 5 errors -> err_cnt stays at 3; in_en held low 10 cycles mid-lock -> no output changes.
REQ-038 Drive 0x03 in HUNT -> no err, stays unlocked; assert res while locked -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared knight-flasher definitions: checker state encoding and the
// phase -> LED index / pattern / direction mapping used by flasher and checker.
package knight_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } knight_state_e;

    // Phases 0..7 sweep up, 8..15 sweep back down; 15-k equals ~k in the low bits.
    function automatic logic [2:0] phase_pos(input logic [3:0] ph);
        return ph[3] ? ~ph[2:0] : ph[2:0];
    endfunction

    function automatic logic [7:0] phase_pattern(input logic [3:0] ph);
        return 8'b0000_0001 << phase_pos(ph);
    endfunction

    function automatic logic phase_dir(input logic [3:0] ph);
        return ph[3];
    endfunction

endpackage

// File: rtl/knight_onehot_dec.sv
// Combinational decode of an 8-bit LED pattern into the lit index and a
// flag telling whether exactly one LED is lit.
module knight_onehot_dec (
    input  logic [7:0] in,
    output logic [2:0] idx,
    output logic       onehot
);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in[i]) idx = 3'(i);
        end
    end

    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign onehot = (in != 8'd0) && ((in & (in - 8'd1)) == 8'd0);

endmodule

// File: rtl/knight_check.sv
// Sequence checker for a knight-rider LED flasher: acquires the sweep from two
// consecutive legal samples, then flags any deviation from the 16-phase order.
module knight_check
    import knight_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             ck,
    input  logic             res,
    input  logic             in_en,
    input  logic [7:0]       in,
    output logic [2:0]       pos,
    output logic             dir,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sweep_cnt
);

    knight_state_e    state, state_nxt;
    logic [2:0]       p, p_nxt;
    logic [3:0]       phase, phase_nxt;
    logic [2:0]       pos_nxt;
    logic             dir_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] err_cnt_nxt, sweep_cnt_nxt;

    logic [2:0]       idx;
    logic             onehot;
    logic [3:0]       phase_inc;
    logic [3:0]       acq_phase;
    logic             acq_hit;

    knight_onehot_dec u_dec (
        .in     (in),
        .idx    (idx),
        .onehot (onehot)
    );

    assign phase_inc = phase + 4'd1;

    // Two consecutive samples pin down the phase; the 0x80/0x01 repeats are
    // the turn-around points and select phase 8 / phase 0 respectively.
    always_comb begin
        acq_hit   = 1'b0;
        acq_phase = 4'd0;
        if (p < 3'd7 && idx == p + 3'd1) begin
            acq_hit   = 1'b1;
            acq_phase = {1'b0, idx};
        end else if (p > 3'd0 && idx == p - 3'd1) begin
            acq_hit   = 1'b1;
            acq_phase = 4'd15 - {1'b0, idx};
        end else if (idx == p && p == 3'd7) begin
            acq_hit   = 1'b1;
            acq_phase = 4'd8;
        end else if (idx == p && p == 3'd0) begin
            acq_hit   = 1'b1;
            acq_phase = 4'd0;
        end
    end

    always_comb begin
        state_nxt     = state;
        p_nxt         = p;
        phase_nxt     = phase;
        pos_nxt       = pos;
        dir_nxt       = dir;
        err_nxt       = 1'b0;
        err_cnt_nxt   = err_cnt;
        sweep_cnt_nxt = sweep_cnt;
        if (in_en) begin
            case (state)
                HUNT: begin
                    if (onehot) begin
                        p_nxt     = idx;
                        pos_nxt   = idx;
                        state_nxt = ACQ;
                    end
                end
                ACQ: begin
                    if (!onehot) begin
                        state_nxt = HUNT;
                    end else begin
                        p_nxt   = idx;
                        pos_nxt = idx;
                        if (acq_hit) begin
                            phase_nxt = acq_phase;
                            dir_nxt   = phase_dir(acq_phase);
                            state_nxt = LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (in == phase_pattern(phase_inc)) begin
                        phase_nxt = phase_inc;
                        pos_nxt   = phase_pos(phase_inc);
                        dir_nxt   = phase_dir(phase_inc);
                        if (phase == 4'd15) sweep_cnt_nxt = sweep_cnt + 1'b1;
                    end else begin
                        // The offending sample is dropped; reacquisition starts fresh.
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                        if (err_cnt != {CNT_W{1'b1}}) err_cnt_nxt = err_cnt + 1'b1;
                        if (onehot) pos_nxt = idx;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (res) begin
            state     <= HUNT;
            p         <= 3'd0;
            phase     <= 4'd0;
            pos       <= 3'd0;
            dir       <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            p         <= p_nxt;
            phase     <= phase_nxt;
            pos       <= pos_nxt;
            dir       <= dir_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_knight_check.sv
// Bench for knight_check: two instances (CNT_W=8 and CNT_W=2) on shared stimulus,
// directed scenarios plus random flasher streams against a search-based model.
module tb_knight_check;

    logic       ck = 1'b0;
    logic       res, in_en;
    logic [7:0] in_v;

    logic [2:0] pos8, pos2;
    logic       dir8, dir2, lk8, lk2, err8, err2;
    logic [7:0] ec8, sc8;
    logic [1:0] ec2, sc2;

    int tests = 0;
    int fails = 0;

    always #5 ck = ~ck;

    knight_check #(.CNT_W(8)) dut8 (
        .ck(ck), .res(res), .in_en(in_en), .in(in_v),
        .pos(pos8), .dir(dir8), .locked(lk8), .err(err8),
        .err_cnt(ec8), .sweep_cnt(sc8)
    );

    knight_check #(.CNT_W(2)) dut2 (
        .ck(ck), .res(res), .in_en(in_en), .in(in_v),
        .pos(pos2), .dir(dir2), .locked(lk2), .err(err2),
        .err_cnt(ec2), .sweep_cnt(sc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: state 0=hunting, 1=acquiring, 2=locked.
    int m_st, m_p, m_ph, m_pos, m_dir, m_err, m_ec8, m_ec2, m_sc8, m_sc2;

    function automatic logic [7:0] pat(input int k);
        int kk;
        kk = k % 16;
        return 8'(1 << ((kk < 8) ? kk : 15 - kk));
    endfunction

    function automatic int idx_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model(input logic r, input logic e, input logic [7:0] v);
        bit oh;
        int q, hit;
        oh    = ($countones(v) == 1);
        q     = idx_of(v);
        m_err = 0;
        if (r) begin
            m_st = 0; m_p = 0; m_ph = 0; m_pos = 0; m_dir = 0;
            m_ec8 = 0; m_ec2 = 0; m_sc8 = 0; m_sc2 = 0;
        end else if (e) begin
            if (m_st == 0) begin
                if (oh) begin m_p = q; m_pos = q; m_st = 1; end
            end else if (m_st == 1) begin
                if (!oh) m_st = 0;
                else begin
                    // Find the unique phase pair (k, k+1) matching previous and current sample.
                    hit = -1;
                    for (int k = 0; k < 16; k++)
                        if (pat(k) == (8'd1 << m_p) && pat(k + 1) == v) hit = (k + 1) % 16;
                    m_p = q; m_pos = q;
                    if (hit >= 0) begin m_ph = hit; m_dir = (hit >= 8); m_st = 2; end
                end
            end else begin
                if (v == pat(m_ph + 1)) begin
                    if (m_ph == 15) begin m_sc8 = (m_sc8 + 1) % 256; m_sc2 = (m_sc2 + 1) % 4; end
                    m_ph  = (m_ph + 1) % 16;
                    m_pos = q;
                    m_dir = (m_ph >= 8);
                end else begin
                    m_err = 1;
                    if (m_ec8 < 255) m_ec8++;
                    if (m_ec2 < 3) m_ec2++;
                    m_st = 0;
                    if (oh) m_pos = q;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check #1 after the rising edge, return to negedge.
    task automatic step(input logic r, input logic e, input logic [7:0] v);
        res = r; in_en = e; in_v = v;
        @(posedge ck);
        #1;
        model(r, e, v);
        chk("pos8", pos8, m_pos);        chk("pos2", pos2, m_pos);
        chk("locked8", lk8, m_st == 2);  chk("locked2", lk2, m_st == 2);
        chk("err8", err8, m_err);        chk("err2", err2, m_err);
        chk("errcnt8", ec8, m_ec8);      chk("errcnt2", ec2, m_ec2);
        chk("sweep8", sc8, m_sc8);       chk("sweep2", sc2, m_sc2);
        if (m_st == 2) begin
            chk("dir8", dir8, m_dir);    chk("dir2", dir2, m_dir);
        end
        @(negedge ck);
    endtask

    logic [2:0] s_pos;
    logic       s_dir, s_lk;
    logic [7:0] s_ec, s_sc;
    int         g, r;

    initial begin
        res = 1'b1; in_en = 1'b0; in_v = 8'd0;
        m_st = 0; m_p = 0; m_ph = 0; m_pos = 0; m_dir = 0; m_err = 0;
        m_ec8 = 0; m_ec2 = 0; m_sc8 = 0; m_sc2 = 0;
        @(negedge ck);

        // Reset with a sample present: sample discarded, everything cleared.
        step(1'b1, 1'b1, 8'h10);
        chk("rst_pos", pos8, 0); chk("rst_locked", lk8, 0); chk("rst_dir", dir8, 0);

        // Acquire on an upward pair.
        step(1'b0, 1'b1, 8'h01);
        chk("acq1_locked", lk8, 0);
        step(1'b0, 1'b1, 8'h02);
        chk("acq2_locked", lk8, 1); chk("acq2_dir", dir8, 0);
        step(1'b0, 1'b1, 8'h04);
        chk("acq3_pos", pos8, 2); chk("acq3_err", err8, 0);

        // 32 flasher steps from phase 2 cross the 15->0 boundary twice.
        for (int k = 3; k < 35; k++) begin
            step(1'b0, 1'b1, pat(k));
            if (k % 16 == 8) chk("turn_down_dir", dir8, 1);
            if (k % 16 == 0) chk("turn_up_dir", dir8, 0);
        end
        chk("sweeps_8", sc8, 2); chk("sweeps_2", sc2, 2); chk("sweeps_err", ec8, 0);

        // Skip a position while going up.
        step(1'b0, 1'b1, 8'h08);
        chk("up3_pos", pos8, 3);
        step(1'b0, 1'b1, 8'h20);
        chk("skip_err", err8, 1); chk("skip_errcnt", ec8, 1); chk("skip_locked", lk8, 0);
        step(1'b0, 1'b1, 8'h40);
        chk("skip_pulse", err8, 0); chk("reacq_locked0", lk8, 0);
        step(1'b0, 1'b1, 8'h80);
        chk("reacq_locked", lk8, 1); chk("reacq_pos", pos8, 7); chk("reacq_dir", dir8, 0);

        // Acquire on the top turn-around.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h80);
        step(1'b0, 1'b1, 8'h80);
        chk("top_locked", lk8, 1); chk("top_dir", dir8, 1);
        step(1'b0, 1'b1, 8'h40);
        chk("top_next_pos", pos8, 6); chk("top_next_locked", lk8, 1);

        // Five errors: wide counter counts, narrow counter saturates.
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 1'b1, 8'h01);
            step(1'b0, 1'b1, 8'h02);
            step(1'b0, 1'b1, 8'h08);
        end
        chk("sat_cnt8", ec8, 5); chk("sat_cnt2", ec2, 3);

        // Hold in_en low mid-lock.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h04);
        s_pos = pos8; s_dir = dir8; s_lk = lk8; s_ec = ec8; s_sc = sc8;
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0, 8'($urandom));
            chk("hold_pos", pos8, s_pos); chk("hold_dir", dir8, s_dir);
            chk("hold_locked", lk8, s_lk); chk("hold_errcnt", ec8, s_ec);
            chk("hold_sweep", sc8, s_sc);
        end

        // Multi-bit sample in HUNT, then reset while locked.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h03);
        chk("multi_err", err8, 0); chk("multi_locked", lk8, 0);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h04);
        step(1'b1, 1'b1, 8'h08);
        chk("rstlk_pos", pos8, 0); chk("rstlk_dir", dir8, 0); chk("rstlk_locked", lk8, 0);
        chk("rstlk_errcnt", ec8, 0); chk("rstlk_sweep", sc8, 0);

        // Random flasher streams with gaps, glitches, jumps and resets.
        g = $urandom_range(0, 15);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       step(1'b1, 1'($urandom), 8'($urandom));
            else if (r < 20) step(1'b0, 1'b0, 8'($urandom));
            else if (r < 23) step(1'b0, 1'b1, 8'($urandom));
            else if (r < 26) step(1'b0, 1'b1, 8'd1 << $urandom_range(0, 7));
            else if (r < 28) begin
                g = $urandom_range(0, 15);
                step(1'b0, 1'b1, pat(g));
                g++;
            end else begin
                step(1'b0, 1'b1, pat(g));
                g++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
